// File: rtl/lcd_delay_timer.sv
// ============================================================================
// Module   : lcd_delay_timer
// Brief    : Programmable one-shot/periodic delay timer with four selectable
//            terminal counts for HD44780-style LCD init/command timing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_delay_timer #(
    parameter int unsigned CNT_WIDTH = 20,
    parameter int unsigned DLY0      = 750000,
    parameter int unsigned DLY1      = 205000,
    parameter int unsigned DLY2      = 82000,
    parameter int unsigned DLY3      = 2000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           sel,
    input  logic                 mode,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] clk_cnt
);

    localparam longint unsigned C_CNT_MAX = (64'd1 << CNT_WIDTH) - 64'd1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [CNT_WIDTH-1:0] C_TERM0 = CNT_WIDTH'(DLY0);
    localparam logic [CNT_WIDTH-1:0] C_TERM1 = CNT_WIDTH'(DLY1);
    localparam logic [CNT_WIDTH-1:0] C_TERM2 = CNT_WIDTH'(DLY2);
    localparam logic [CNT_WIDTH-1:0] C_TERM3 = CNT_WIDTH'(DLY3);

    // A terminal count that would be truncated by the counter is a build error.
    generate
        if ((longint'(DLY0) > C_CNT_MAX) || (longint'(DLY1) > C_CNT_MAX) ||
            (longint'(DLY2) > C_CNT_MAX) || (longint'(DLY3) > C_CNT_MAX)) begin : g_dly_range_err
            $error("lcd_delay_timer: a DLYn value does not fit in CNT_WIDTH bits");
        end
    endgenerate

    logic [0:0]           r_state;
    logic [CNT_WIDTH-1:0] r_term;
    logic                 r_mode;
    logic [CNT_WIDTH-1:0] w_sel_term;
    logic                 w_at_term;

    always_comb begin
        w_sel_term = C_TERM0;
        case (sel)
            2'd0:    w_sel_term = C_TERM0;
            2'd1:    w_sel_term = C_TERM1;
            2'd2:    w_sel_term = C_TERM2;
            default: w_sel_term = C_TERM3;
        endcase
    end

    assign w_at_term = (clk_cnt == r_term);
    assign busy      = (r_state == ST_RUN);

    // Priority: reset > abort > start > counting. Abort keeps the latched term/mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_term  <= C_TERM0;
            r_mode  <= 1'b0;
            clk_cnt <= '0;
            done    <= 1'b0;
        end else if (abort) begin
            r_state <= ST_IDLE;
            clk_cnt <= '0;
            done    <= 1'b0;
        end else if (start) begin
            r_state <= ST_RUN;
            r_term  <= w_sel_term;
            r_mode  <= mode;
            clk_cnt <= '0;
            done    <= 1'b0;
        end else if (r_state == ST_RUN) begin
            if (w_at_term) begin
                done    <= 1'b1;
                clk_cnt <= '0;
                if (!r_mode) begin
                    r_state <= ST_IDLE;
                end
            end else begin
                done    <= 1'b0;
                clk_cnt <= clk_cnt + CNT_WIDTH'(1);
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

`default_nettype wire
